red_iterativa_serial: RTL
=========================

RED_ITERATIVA_SERIAL -- requirements
Module: red_iterativa_serial

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the operand width in bits; legal range 1..32.
REQ-002 Port clk SHALL be an input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port inicio SHALL be an input, 1 bit: start request, sampled only while listo=1.
REQ-005 Port A SHALL be an input, N bits: first operand, captured when a start is accepted.
REQ-006 Port B SHALL be an input, N bits: second operand, captured when a start is accepted.
REQ-007 Port listo SHALL be an output, 1 bit: high when the block can accept a start.
REQ-008 Port valido SHALL be an output, 1 bit: one-cycle pulse marking a new result on W.
REQ-009 Port W SHALL be an output, 1 bit: comparison result, 1 iff unsigned A > B.

Function
REQ-010 The block SHALL evaluate the iterative comparator network bit-serially, one bit per cycle, from LSB to MSB (right to left).
REQ-011 The FSM SHALL have exactly three states: REPOSO, PROCESO and FIN.
REQ-012 In REPOSO, listo SHALL be 1; in PROCESO and FIN, listo SHALL be 0.
REQ-013 A start SHALL be accepted on an edge where the state is REPOSO and inicio=1.
- On acceptance: A and B are loaded into internal shift registers, bit counter = 0, accumulator = 0, next state = PROCESO.
REQ-014 On an edge in PROCESO, the block SHALL consume bit i (counter value) as follows:
- i=0 (initial cell): acc <= A0 & ~B0.
- i>0: acc <= (Ai & ~Bi) | (~(Ai ^ Bi) & acc).
- Then shift the operands right and increment the counter.
REQ-015 The edge that consumes bit N-1 SHALL:
- write the final cell result directly into W;
- move the state to FIN.
REQ-016 In FIN, valido SHALL be 1 for exactly one cycle; the next edge SHALL return the state to REPOSO unconditionally.
REQ-017 Latency: with inicio high in cycle k (accepted at the end of k), cycles k+1..k+N SHALL be PROCESO and valido SHALL be 1 in cycle k+N+1.
- Minimum start-to-start period: N+2 cycles.
REQ-018 W SHALL hold its value from the FIN entry until the next FIN entry.
- It SHALL NOT change during PROCESO.
REQ-019 inicio SHALL be ignored in PROCESO and FIN.
- A and B changes after acceptance SHALL NOT affect the running comparison.
REQ-020 If inicio is held high continuously, a new start SHALL be accepted on the first REPOSO cycle after each FIN.
REQ-021 The counter SHALL be ceil(log2(N)) bits (minimum 1) and SHALL never exceed N-1.
REQ-022 For N=1, PROCESO SHALL last one cycle and apply only the initial-cell rule.
REQ-023 Equal operands SHALL yield W=0.
REQ-024 The state encoding SHALL have no unreachable-state lockup: any illegal encoding SHALL go to REPOSO on the next edge.

Reset
REQ-025 While rst=1 at an edge, the block SHALL set:
- state = REPOSO;
- W = 0, valido = 0;
- counter, accumulator and shift registers = 0.
REQ-026 Outputs SHALL be listo=1, valido=0, W=0 in the first cycle after the reset edge.
REQ-027 rst SHALL take priority over inicio and over any in-progress comparison.
- A comparison aborted by reset SHALL produce no valido pulse.
REQ-028 No output SHALL change asynchronously to clk.

Verification
REQ-029 With N=8, A=8'h05, B=8'h03, inicio pulsed in cycle k -> valido=1 in cycle k+9 with W=1; listo=0 in cycles k+1..k+9.
REQ-030 With A=8'hA5, B=8'hA5 -> W=0 at the valido pulse.
- A=8'h80, B=8'h7F -> W=1 (MSB dominates the lower bits).
- A=8'h7F, B=8'h80 -> W=0.
REQ-031 A=8'h01, B=8'h00 -> W=1 (decided by the initial cell only).
- A=8'h00, B=8'h01 -> W=0.
REQ-032 rst asserted in cycle k+4 of a running comparison ->
- no valido pulse;
- listo=1 and W=0 in the next cycle;
- a following start completes normally.
REQ-033 inicio held high for 30 cycles with A=8'hFF, B=8'h00 ->
- valido pulses exactly every 10 cycles;
- W=1 on each pulse;
- A/B changes during PROCESO do not alter the result.
REQ-034 Parameter N=1 with A=1, B=0 -> valido in cycle k+2, W=1; A=1, B=1 -> W=0.

Source files
------------

// File: rtl/red_iterativa_serial.sv
// Bit-serial unsigned comparator: W=1 iff A > B, evaluated LSB first.
// Ports: clk, rst (sync, high), inicio/A/B in; listo, valido, W out.
module red_iterativa_serial #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inicio,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         listo,
  output logic         valido,
  output logic         W
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] ULT = CW'(N - 1);

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    PROCESO = 2'd1,
    FIN     = 2'd2
  } est_t;

  est_t          est_q;
  logic [N-1:0]  a_q, b_q;
  logic [CW-1:0] cnt_q;
  logic          acc_q;
  logic          w_q;
  logic          listo_q;
  logic          valido_q;

  logic gt, eq, acc_d;

  // One cell of the iterative network; a higher bit that differs
  // overrides whatever the lower bits decided.
  assign gt    = a_q[0] & ~b_q[0];
  assign eq    = ~(a_q[0] ^ b_q[0]);
  assign acc_d = (cnt_q == '0) ? gt : (gt | (eq & acc_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      est_q    <= REPOSO;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      acc_q    <= 1'b0;
      w_q      <= 1'b0;
      listo_q  <= 1'b1;
      valido_q <= 1'b0;
    end else begin
      case (est_q)
        REPOSO: begin
          if (inicio) begin
            a_q     <= A;
            b_q     <= B;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            listo_q <= 1'b0;
            est_q   <= PROCESO;
          end
        end
        PROCESO: begin
          acc_q <= acc_d;
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          if (cnt_q == ULT) begin
            w_q      <= acc_d;
            valido_q <= 1'b1;
            est_q    <= FIN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        FIN: begin
          valido_q <= 1'b0;
          listo_q  <= 1'b1;
          est_q    <= REPOSO;
        end
        default: begin
          // Recover from an illegal encoding without lockup.
          valido_q <= 1'b0;
          listo_q  <= 1'b1;
          est_q    <= REPOSO;
        end
      endcase
    end
  end

  assign listo  = listo_q;
  assign valido = valido_q;
  assign W      = w_q;

endmodule
